// File: rtl/ram_pkg.sv
// Shared definitions for the synchronous RAM controller: FSM encodings and
// the legal read-latency window.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } ram_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/sp_ram_core.sv
// Single-port DATA_W x 2**ADDR_W array with one registered read/write port.
// The read register keeps its previous value on write cycles.
module sp_ram_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sync_ram_ctrl.sv
// Request/response wrapper around sp_ram_core: zero-fill sequencer after
// reset, fixed-latency read response pipe and a held read-data output.
module sync_ram_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    generate
        if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
            $error("sync_ram_ctrl: RD_LAT must lie in 1..3");
        end
    endgenerate

    ram_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // The counter stops on its all-ones value instead of wrapping to 0.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        req_ready   = 1'b0;
        busy        = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (&clr_cnt) begin
                    state_nxt = ST_IDLE;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
            end
        endcase
    end

    logic              clearing;
    logic              req_acc;
    logic              rd_acc;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] rdata_p0;

    // Nothing touches the array on the reset edge itself.
    assign clearing   = (state == ST_CLEAR);
    assign req_acc    = !rst && req_valid && req_ready;
    assign rd_acc     = req_acc && !req_we;
    assign core_we    = !rst && (clearing || (req_acc && req_we));
    assign core_addr  = clearing ? clr_cnt : req_addr;
    assign core_wdata = clearing ? '0 : req_wdata;

    sp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .addr  (core_addr),
        .wdata (core_wdata),
        .rdata (rdata_p0)
    );

    // --- stage p0: core output register; later stages delay it to RD_LAT ---
    logic [RD_LAT-1:0] vld_p;
    logic [DATA_W-1:0] rsp_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rsp_dat = rdata_p0;
        end else begin : g_latn
            logic [DATA_W-1:0] dat_p [1:RD_LAT-1];
            always_ff @(posedge clk) begin
                dat_p[1] <= rdata_p0;
                for (int i = 2; i < RD_LAT; i++) begin
                    dat_p[i] <= dat_p[i-1];
                end
            end
            assign rsp_dat = dat_p[RD_LAT-1];
        end
    endgenerate

    // --- output: hold register keeps the last delivered word ---
    logic [DATA_W-1:0] rsp_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_hold <= '0;
        end else if (rsp_valid) begin
            rsp_hold <= rsp_dat;
        end
    end

    assign rsp_valid = vld_p[RD_LAT-1];
    assign rsp_rdata = rsp_valid ? rsp_dat : rsp_hold;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Bench for sync_ram_ctrl: four instances (RD_LAT 1/2/3 with clear, RD_LAT 3
// without clear) share one stimulus stream and are compared to a cycle model.
module tb_sync_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;

    logic [3:0] rv;
    logic [3:0] rdy;
    logic [3:0] bsy;
    logic [7:0] rd [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .busy(bsy[0]));

    sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2), .CLEAR_ON_RST(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .busy(bsy[1]));

    sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(3), .CLEAR_ON_RST(1)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .busy(bsy[2]));

    sync_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(3), .CLEAR_ON_RST(0)) u3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[3]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[3]), .rsp_rdata(rd[3]), .busy(bsy[3]));

    // Reference model: memory contents, remaining clear cycles, and reads
    // scheduled by the cycle number on which their response is due.
    int         lat [4];
    int         clr [4];
    int         mcnt [4];
    logic [7:0] mmem [4][16];
    bit         mknown [4][16];
    bit         pv [4][8];
    logic [7:0] pd [4][8];
    bit         pk [4][8];
    logic [7:0] mhold [4];
    bit         hknown [4];
    int         cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic w,
                        input logic [3:0] a, input logic [7:0] d);
        int ne;
        int s;
        rst       = r;
        req_valid = v;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        ne = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                mcnt[k] = (clr[k] != 0) ? 16 : 0;
                for (int j = 0; j < 8; j++) pv[k][j] = 1'b0;
                mhold[k]  = 8'h00;
                hknown[k] = 1'b1;
            end else if (v && mcnt[k] == 0) begin
                if (w) begin
                    mmem[k][a]   = d;
                    mknown[k][a] = 1'b1;
                end else begin
                    s = (ne + lat[k] - 1) % 8;
                    pv[k][s] = 1'b1;
                    pd[k][s] = mmem[k][a];
                    pk[k][s] = mknown[k][a];
                end
            end else if (mcnt[k] > 0) begin
                mcnt[k]--;
                if (mcnt[k] == 0) begin
                    for (int j = 0; j < 16; j++) begin
                        mmem[k][j]   = 8'h00;
                        mknown[k][j] = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        cyc = ne;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            s = cyc % 8;
            if (pv[k][s]) begin
                chk($sformatf("u%0d_rsp_valid", k), {31'd0, rv[k]}, 32'd1);
                if (pk[k][s]) chk($sformatf("u%0d_rsp_rdata", k), {24'd0, rd[k]}, {24'd0, pd[k][s]});
                pv[k][s]  = 1'b0;
                mhold[k]  = pd[k][s];
                hknown[k] = pk[k][s];
            end else begin
                chk($sformatf("u%0d_rsp_valid", k), {31'd0, rv[k]}, 32'd0);
                if (hknown[k]) chk($sformatf("u%0d_rsp_hold", k), {24'd0, rd[k]}, {24'd0, mhold[k]});
            end
            chk($sformatf("u%0d_busy", k), {31'd0, bsy[k]}, (mcnt[k] > 0) ? 32'd1 : 32'd0);
            chk($sformatf("u%0d_req_ready", k), {31'd0, rdy[k]}, (mcnt[k] == 0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    initial begin
        lat = '{1, 2, 3, 3};
        clr = '{1, 1, 1, 0};
        for (int k = 0; k < 4; k++) begin
            mcnt[k]   = 0;
            mhold[k]  = 8'h00;
            hknown[k] = 1'b0;
            for (int j = 0; j < 16; j++) mknown[k][j] = 1'b0;
            for (int j = 0; j < 8; j++) pv[k][j] = 1'b0;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset and clear, then read every address back
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(16);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
        idle(4);

        // Write then read in the following cycle
        step(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        idle(4);

        // Streaming writes then back-to-back reads
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 4'(i), 8'(i + 16));
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
        idle(4);

        // Reset mid-clear with nonzero data at address 12
        step(1'b0, 1'b1, 1'b1, 4'd12, 8'h5C);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(16);
        step(1'b0, 1'b1, 1'b0, 4'd12, 8'h00);
        idle(4);

        // Reset with two reads in flight
        step(1'b0, 1'b1, 1'b1, 4'd3, 8'h3C);
        step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        step(1'b0, 1'b1, 1'b0, 4'd4, 8'h00);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(17);
        step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        idle(4);

        // Request held through CLEAR
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            bit was_idle;
            was_idle = (mcnt[0] == 0);
            step(1'b0, 1'b1, 1'b1, 4'd5, 8'h77);
            if (was_idle) break;
        end
        step(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
        idle(4);

        // Random mixed traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            logic r, v, w;
            r = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            step(r, v, w, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
